// File: rtl/ddr_bist_gen.sv
// DDR BIST generator: writes NUM_WORDS pattern words, reads them back and counts mismatches.
// Define BIST_PRBS_EN for a 32-bit PRBS pattern; default pattern is the inverted word index.
module ddr_bist_gen #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rw,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // WRITE | issuing write commands, index = cmd_addr
    // READ  | issuing read commands, checking returns as they arrive
    // DRAIN | all reads issued, waiting for outstanding returns
    // DONE  | result latched in done/pass/err_cnt, start reruns
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam int OUT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  out_nxt;
    logic [15:0]       err_nxt;
    logic [DATA_W-1:0] wr_first;
    logic [DATA_W-1:0] wr_next;
    logic [DATA_W-1:0] chk_exp;
    logic              start_ok;
    logic              hs;
    logic              chk_fire;
    logic              rd_inc;
    logic              rd_dec;
    logic              mismatch;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign hs       = cmd_valid && cmd_ready;
    assign chk_fire = rd_valid && (state == READ || state == DRAIN);
    assign rd_inc   = (state == READ) && hs;
    // A return with nothing outstanding is a manager fault; never let the counter wrap.
    assign rd_dec   = chk_fire && (outstanding != '0 || rd_inc);
    assign mismatch = chk_fire && (rd_data != chk_exp);

`ifdef BIST_PRBS_EN
    localparam logic [31:0] PRBS_SEED = 32'hACE1_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    logic [31:0] chk_lfsr;

    // The write data register doubles as the writer's LFSR state.
    assign wr_first = DATA_W'(PRBS_SEED);
    assign wr_next  = DATA_W'(lfsr_step(32'(wr_data)));
    assign chk_exp  = DATA_W'(chk_lfsr);

    always_ff @(posedge clk) begin
        if (!rst_n)
            chk_lfsr <= '0;
        else if (start_ok)
            chk_lfsr <= PRBS_SEED;
        else if (chk_fire)
            chk_lfsr <= lfsr_step(chk_lfsr);
    end
`else
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] i);
        return ~(DATA_W'(i));
    endfunction

    logic [ADDR_W-1:0] chk_idx;

    assign wr_first = pattern('0);
    assign wr_next  = pattern(cmd_addr + ADDR_W'(1));
    assign chk_exp  = pattern(chk_idx);

    always_ff @(posedge clk) begin
        if (!rst_n)
            chk_idx <= '0;
        else if (start_ok)
            chk_idx <= '0;
        else if (chk_fire)
            chk_idx <= chk_idx + ADDR_W'(1);
    end
`endif

    always_comb begin
        out_nxt = outstanding;
        if (rd_inc && !rd_dec)
            out_nxt = outstanding + OUT_W'(1);
        else if (!rd_inc && rd_dec)
            out_nxt = outstanding - OUT_W'(1);
    end

    always_comb begin
        err_nxt = err_cnt;
        if (mismatch && err_cnt != 16'hFFFF)
            err_nxt = err_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            outstanding <= '0;
            cmd_valid   <= 1'b0;
            cmd_rw      <= 1'b0;
            cmd_addr    <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= WRITE;
                        outstanding <= '0;
                        cmd_valid   <= 1'b1;
                        cmd_rw      <= 1'b0;
                        cmd_addr    <= '0;
                        wr_data     <= wr_first;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        err_cnt     <= '0;
                    end
                end
                WRITE: begin
                    if (hs) begin
                        if (cmd_addr == LAST_IDX) begin
                            state    <= READ;
                            cmd_rw   <= 1'b1;
                            cmd_addr <= '0;
                        end else begin
                            cmd_addr <= cmd_addr + ADDR_W'(1);
                            wr_data  <= wr_next;
                        end
                    end
                end
                READ: begin
                    outstanding <= out_nxt;
                    err_cnt     <= err_nxt;
                    if (hs) begin
                        if (cmd_addr == LAST_IDX) begin
                            state     <= DRAIN;
                            cmd_valid <= 1'b0;
                            cmd_addr  <= '0;
                        end else begin
                            cmd_addr <= cmd_addr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    outstanding <= out_nxt;
                    err_cnt     <= err_nxt;
                    // Use the post-update values so a final return landing now is counted.
                    if (out_nxt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 16'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ddr_bist_gen.md
DDR_BIST_GEN -- requirements
Module: ddr_bist_gen

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 24, width of the word address.
REQ-002 The block SHALL have parameter DATA_W, default 32, width of one data word.
REQ-003 The block SHALL have parameter NUM_WORDS, default 256, words per pass (2..2^ADDR_W).
REQ-004 The block SHALL have port clk, input, 1, the single clock for all logic (memory-controller user clock).
REQ-005 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1, a one-cycle pulse that launches one write-then-read pass.
REQ-007 The block SHALL have port cmd_valid, output, 1, command request to the DDR manager.
REQ-008 The block SHALL have port cmd_ready, input, 1, command accepted by the DDR manager.
REQ-009 The block SHALL have port cmd_rw, output, 1, command type (0=write, 1=read).
REQ-010 The block SHALL have port cmd_addr, output, ADDR_W, command word address.
REQ-011 The block SHALL have port wr_data, output, DATA_W, write data, qualified with a write command.
REQ-012 The block SHALL have port rd_valid, input, 1, read-return strobe, returns in issue order.
REQ-013 The block SHALL have port rd_data, input, DATA_W, read-return data.
REQ-014 The block SHALL have port busy, output, 1, high while a pass runs.
REQ-015 The block SHALL have port done, output, 1, level, set at pass end.
REQ-016 The block SHALL have port pass, output, 1, level, done with zero mismatches.
REQ-017 The block SHALL have port err_cnt, output, 16, mismatch count, saturating.

Function
REQ-018 The FSM SHALL use states IDLE, WRITE, READ, DRAIN and DONE.
REQ-019 On start in IDLE or DONE, the FSM SHALL clear done, pass and err_cnt, reset both pattern generators, zero the address and outstanding counters, and go to WRITE on the next cycle.
REQ-020 start SHALL be ignored in WRITE, READ and DRAIN.
REQ-021 In WRITE, the block SHALL hold cmd_valid=1 with cmd_rw=0, cmd_addr=index and wr_data=pattern(index).
REQ-022 A handshake (cmd_valid & cmd_ready) SHALL advance the index, and the command fields SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-023 After the write handshake for index NUM_WORDS-1, the FSM SHALL reset the index to 0 and go to READ.
REQ-024 In READ, the block SHALL issue read commands for indexes 0..NUM_WORDS-1 under the same handshake rules, with cmd_rw=1.
REQ-025 After the last read handshake, the FSM SHALL go to DRAIN.
REQ-026 The outstanding counter SHALL increment per read handshake and decrement per rd_valid, and a same-cycle handshake and rd_valid SHALL leave it unchanged.
REQ-027 Each rd_valid in READ or DRAIN SHALL compare rd_data with the checker's expected pattern, then advance the checker.
REQ-028 A mismatch SHALL increment err_cnt, which saturates at 0xFFFF.
REQ-029 rd_valid in IDLE, WRITE or DONE SHALL be ignored.
REQ-030 When DRAIN has outstanding=0, the FSM SHALL go to DONE, set done=1 and set pass=(err_cnt==0), including a compare landing that same cycle.
REQ-031 The FSM SHALL hold cmd_valid=0 in IDLE, DRAIN and DONE.
REQ-032 busy SHALL be 1 exactly in WRITE, READ and DRAIN.
REQ-033 Latency from start to the first cmd_valid SHALL be 1 cycle.

Reset
REQ-034 With rst_n=0 at a clk edge, the block SHALL go to state IDLE.
REQ-035 Under reset, the block SHALL drive cmd_valid=0, cmd_rw=0, cmd_addr=0, wr_data=0, busy=0, done=0, pass=0 and err_cnt=0, and clear all counters.
REQ-036 Reset mid-pass SHALL abandon the pass immediately, with no further commands.
REQ-037 After a reset mid-pass, late rd_valid pulses SHALL be ignored.

Configuration
REQ-038 Macro BIST_PRBS_EN SHALL select the data pattern.
REQ-039 With BIST_PRBS_EN undefined, pattern(i) SHALL be the bitwise inverse of i zero-extended to DATA_W.
REQ-040 With BIST_PRBS_EN defined, pattern SHALL come from a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, seed 0xACE10001.
REQ-041 The writer and the checker SHALL each hold an LFSR, advanced per write handshake and per rd_valid respectively, and DATA_W SHALL equal 32.

Verification
REQ-042 NUM_WORDS=4, cmd_ready=1, loopback memory model, start -> writes to addresses 0..3 with data FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC, then 4 reads, then done=1, pass=1, err_cnt=0.
REQ-043 cmd_ready toggled pseudo-randomly with 3-cycle read-return latency -> fields stable during stalls, exactly 4+4 handshakes, pass=1.
REQ-044 Model corrupts read data at address 2 (bit 0 flipped) -> err_cnt=1, pass=0, done=1.
REQ-045 rst_n=0 asserted after 2 write handshakes, released, then start -> the pass restarts at address 0 and the late rd_valid pulses are ignored.
REQ-046 start pulses during busy, and a start after done -> the busy pulses are ignored, and the post-done start clears done, pass and err_cnt and reruns the pass.
REQ-047 BIST_PRBS_EN defined -> the first write data is 0xACE10001 and the checker matches the loopback, pass=1.
